// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Brief    : MIPS add/sub/sll/sra/addi decode into a two-entry skid buffer
//            feeding the ALU stage. Optional macro ILLEGAL_TRAP_EN drops
//            unsupported beats and raises a sticky illegal flag.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue #(
    parameter int IMM_SIGNED = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  ALUCtl,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic        illegal
);

    localparam logic [5:0] c_OP_SPECIAL = 6'h00;
    localparam logic [5:0] c_OP_ADDI    = 6'h08;
    localparam logic [5:0] c_FN_SLL     = 6'h00;
    localparam logic [5:0] c_FN_SRA     = 6'h03;
    localparam logic [5:0] c_FN_ADD     = 6'h20;
    localparam logic [5:0] c_FN_SUB     = 6'h22;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_skid_ctl;
    logic [31:0] r_skid_a;
    logic [31:0] r_skid_b;

    logic [31:0] w_imm;
    logic [31:0] w_shamt;
    logic [1:0]  w_ctl;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_ill;
    logic [1:0]  w_e_ctl;
    logic [31:0] w_e_a;
    logic [31:0] w_e_b;
    logic        w_in_fire;
    logic        w_push;
    logic        w_pop;
    logic        w_unused_instr;

    assign w_unused_instr = ^instr[25:16];
    assign w_shamt        = {27'b0, instr[10:6]};

    generate
        if (IMM_SIGNED != 0) begin : g_imm_sext
            assign w_imm = {{16{instr[15]}}, instr[15:0]};
        end else begin : g_imm_zext
            assign w_imm = {16'b0, instr[15:0]};
        end
    endgenerate

    always_comb begin
        w_ctl = 2'd0;
        w_a   = rs_val;
        w_b   = rt_val;
        w_ill = 1'b0;
        if (instr[31:26] == c_OP_SPECIAL) begin
            case (instr[5:0])
                c_FN_ADD: w_ctl = 2'd0;
                c_FN_SUB: w_ctl = 2'd1;
                c_FN_SLL: begin
                    w_ctl = 2'd2;
                    w_a   = rt_val;
                    w_b   = w_shamt;
                end
                c_FN_SRA: begin
                    w_ctl = 2'd3;
                    w_a   = rt_val;
                    w_b   = w_shamt;
                end
                default: w_ill = 1'b1;
            endcase
        end else if (instr[31:26] == c_OP_ADDI) begin
            w_b = w_imm;
        end else begin
            w_ill = 1'b1;
        end
    end

    // Unsupported beats become an add of zeros (a nop) when they are forwarded.
    assign w_e_ctl   = w_ill ? 2'd0  : w_ctl;
    assign w_e_a     = w_ill ? 32'd0 : w_a;
    assign w_e_b     = w_ill ? 32'd0 : w_b;

    assign w_in_fire = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;

    assign w_push  = w_in_fire & ~w_ill;
    assign illegal = r_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (w_in_fire && w_ill) begin
            r_illegal <= 1'b1;
        end
    end
`else
    assign w_push  = w_in_fire;
    assign illegal = 1'b0;
`endif

    // ALUCtl/A/B are the head entry; the skid entry only fills while the head stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            ALUCtl     <= 2'd0;
            A          <= 32'd0;
            B          <= 32'd0;
            r_skid_ctl <= 2'd0;
            r_skid_a   <= 32'd0;
            r_skid_b   <= 32'd0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    in_ready <= 1'b1;
                    if (w_push) begin
                        ALUCtl    <= w_e_ctl;
                        A         <= w_e_a;
                        B         <= w_e_b;
                        out_valid <= 1'b1;
                        r_state   <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_push && !w_pop) begin
                        r_skid_ctl <= w_e_ctl;
                        r_skid_a   <= w_e_a;
                        r_skid_b   <= w_e_b;
                        in_ready   <= 1'b0;
                        r_state    <= S_FULL;
                    end else if (w_pop && !w_push) begin
                        out_valid <= 1'b0;
                        r_state   <= S_EMPTY;
                    end else if (w_push && w_pop) begin
                        ALUCtl <= w_e_ctl;
                        A      <= w_e_a;
                        B      <= w_e_b;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        ALUCtl   <= r_skid_ctl;
                        A        <= r_skid_a;
                        B        <= r_skid_b;
                        in_ready <= 1'b1;
                        r_state  <= S_ONE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    r_state   <= S_EMPTY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
